// File: rtl/uart_fifo_xrun_pkg.sv
// Shared helpers for the UART FIFO: overrun-policy names, the policy enum and the
// elaboration-time sizing functions.
package uart_fifo_xrun_pkg;

    localparam string XRUN_KEEP      = "KEEP";
    localparam string XRUN_OVERWRITE = "OVERWRITE";

    typedef enum logic {
        XRUN_POL_KEEP,
        XRUN_POL_OVERWRITE
    } xrun_pol_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset on purpose so the array maps onto block RAM or LUT RAM.
module fifo_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-before-write on a shared address: the reader sees the old word.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_fifo_xrun.sv
// Synchronous UART buffering FIFO with occupancy count, almost flags, selectable
// overrun policy and sticky overrun/underrun status.
module uart_fifo_xrun
    import uart_fifo_xrun_pkg::*;
#(
    parameter int    DATA_WIDTH    = 8,
    parameter int    FIFO_SIZE     = 16,
    parameter string XRUN_MODE     = "KEEP",
    parameter int    AFULL_THRESH  = 12,
    parameter int    AEMPTY_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic [clog2(FIFO_SIZE):0]  dcount,
    output logic                       empty,
    output logic                       full,
    output logic                       aempty,
    output logic                       afull,
    input  logic                       xrun_clr,
    output logic                       ovr,
    output logic                       udr
);

    localparam int FIFO_IDX_W = clog2(FIFO_SIZE);
    localparam int CNT_W      = FIFO_IDX_W + 1;
    localparam xrun_pol_e POLICY = (XRUN_MODE == XRUN_OVERWRITE) ? XRUN_POL_OVERWRITE
                                                                 : XRUN_POL_KEEP;
    localparam logic [CNT_W-1:0] SIZE_C   = CNT_W'(FIFO_SIZE);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    if (DATA_WIDTH < 1) begin : g_err_width
        $error("uart_fifo_xrun: DATA_WIDTH must be >= 1");
    end
    if (!is_pow2(FIFO_SIZE)) begin : g_err_size
        $error("uart_fifo_xrun: FIFO_SIZE must be a power of two >= 2");
    end
    if (XRUN_MODE != XRUN_KEEP && XRUN_MODE != XRUN_OVERWRITE) begin : g_err_mode
        $error("uart_fifo_xrun: XRUN_MODE must be KEEP or OVERWRITE");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_SIZE) begin : g_err_afull
        $error("uart_fifo_xrun: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= FIFO_SIZE) begin : g_err_aempty
        $error("uart_fifo_xrun: AEMPTY_THRESH out of range");
    end

    logic [FIFO_IDX_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  dout_valid_reg, ovr_reg, udr_reg;
    logic                  dout_zero_reg;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic rd_acc, wr_acc, wr_ovw, ovr_evt, udr_evt, ram_we, ram_re;

    // Flags come only from the registered count, never from the requests.
    assign empty  = (count_reg == '0);
    assign full   = (count_reg == SIZE_C);
    assign aempty = (count_reg <= AEMPTY_C);
    assign afull  = (count_reg >= AFULL_C);

    assign rd_acc  = rd && !empty;
    assign wr_acc  = wr && (!full || rd_acc);
    assign ovr_evt = wr && full && !rd_acc;
    assign wr_ovw  = ovr_evt && (POLICY == XRUN_POL_OVERWRITE);
    assign udr_evt = rd && empty;
    assign ram_we  = (wr_acc || wr_ovw) && !rst;
    assign ram_re  = rd_acc && !rst;

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_SIZE),
        .ADDR_W     (FIFO_IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            dout_valid_reg <= 1'b0;
            ovr_reg        <= 1'b0;
            udr_reg        <= 1'b0;
            dout_zero_reg  <= 1'b1;
        end else begin
            if (ram_we) wr_ptr_reg <= wr_ptr_reg + FIFO_IDX_W'(1);
            // Overwrite advances the read side too, discarding the oldest word.
            if (rd_acc || wr_ovw) rd_ptr_reg <= rd_ptr_reg + FIFO_IDX_W'(1);
            if (wr_acc && !rd_acc)
                count_reg <= count_reg + CNT_W'(1);
            else if (rd_acc && !wr_acc)
                count_reg <= count_reg - CNT_W'(1);
            dout_valid_reg <= rd_acc;
            if (rd_acc) dout_zero_reg <= 1'b0;
            ovr_reg <= ovr_evt || (ovr_reg && !xrun_clr);
            udr_reg <= udr_evt || (udr_reg && !xrun_clr);
        end
    end

    // The RAM has no reset, so dout reads as zero until the first accepted read.
    assign dout       = dout_zero_reg ? '0 : ram_rdata;
    assign dout_valid = dout_valid_reg;
    assign dcount     = count_reg;
    assign ovr        = ovr_reg;
    assign udr        = udr_reg;

`ifdef FORMAL
    logic [FIFO_IDX_W-1:0] ptr_diff;
    assign ptr_diff = wr_ptr_reg - rd_ptr_reg;

    always @(posedge clk) begin
        if (!rst) begin
            assert (full ? (ptr_diff == '0) : (count_reg == {1'b0, ptr_diff}));
            assert (!(full && empty));
            assert (count_reg <= SIZE_C);
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_xrun.sv
// Bench for uart_fifo_xrun: a KEEP and an OVERWRITE instance share one stimulus stream
// and are checked each cycle against a queue-based model, plus tables and directed sequences.
module tb_uart_fifo_xrun;

    logic       clk = 1'b0;
    logic       rst = 1'b0, wr = 1'b0, rd = 1'b0, xrun_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] k_dout, o_dout;
    logic [4:0] k_dcount, o_dcount;
    logic       k_valid, k_empty, k_full, k_aempty, k_afull, k_ovr, k_udr;
    logic       o_valid, o_empty, o_full, o_aempty, o_afull, o_ovr, o_udr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_fifo_xrun #(.DATA_WIDTH(8), .FIFO_SIZE(16), .XRUN_MODE("KEEP"),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_keep (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
        .dout(k_dout), .dout_valid(k_valid), .dcount(k_dcount),
        .empty(k_empty), .full(k_full), .aempty(k_aempty), .afull(k_afull),
        .xrun_clr(xrun_clr), .ovr(k_ovr), .udr(k_udr));

    uart_fifo_xrun #(.DATA_WIDTH(8), .FIFO_SIZE(16), .XRUN_MODE("OVERWRITE"),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_ovw (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
        .dout(o_dout), .dout_valid(o_valid), .dcount(o_dcount),
        .empty(o_empty), .full(o_full), .aempty(o_aempty), .afull(o_afull),
        .xrun_clr(xrun_clr), .ovr(o_ovr), .udr(o_udr));

    // Reference model: one queue per policy, word order is the FIFO order.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_dout [2];
    bit         m_valid[2];
    bit         m_ovr  [2];
    bit         m_udr  [2];

    function automatic int q_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int m, input logic [7:0] v);
        if (m == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic q_pop(input int m, output logic [7:0] v);
        if (m == 0) v = q0.pop_front(); else v = q1.pop_front();
    endtask

    task automatic model_step(input bit r, input bit w, input bit rq, input bit c,
                              input logic [7:0] d);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                if (m == 0) q0.delete(); else q1.delete();
                m_dout[m] = 8'h00; m_valid[m] = 0; m_ovr[m] = 0; m_udr[m] = 0;
            end else begin
                bit was_full, was_empty, rd_ok, ovr_ev;
                logic [7:0] tmp;
                was_full  = (q_size(m) == 16);
                was_empty = (q_size(m) == 0);
                rd_ok     = rq && !was_empty;
                ovr_ev    = 0;
                if (rd_ok) begin
                    q_pop(m, tmp);
                    m_dout[m] = tmp;
                end
                m_valid[m] = rd_ok;
                if (w) begin
                    if (!was_full || rd_ok) q_push(m, d);
                    else begin
                        ovr_ev = 1;
                        if (m == 1) begin
                            q_pop(m, tmp);
                            q_push(m, d);
                        end
                    end
                end
                m_ovr[m] = ovr_ev || (m_ovr[m] && !c);
                m_udr[m] = (rq && was_empty) || (m_udr[m] && !c);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int m, input string p, input logic [4:0] dc,
                            input logic [7:0] dq, input logic v, input logic em,
                            input logic fu, input logic ae, input logic af,
                            input logic ov, input logic ud);
        int n;
        n = q_size(m);
        chk({p, " dcount"},     32'(dc), 32'(n));
        chk({p, " dout"},       32'(dq), 32'(m_dout[m]));
        chk({p, " dout_valid"}, 32'(v),  32'(m_valid[m]));
        chk({p, " empty"},      32'(em), 32'(n == 0));
        chk({p, " full"},       32'(fu), 32'(n == 16));
        chk({p, " aempty"},     32'(ae), 32'(n <= 4));
        chk({p, " afull"},      32'(af), 32'(n >= 12));
        chk({p, " ovr"},        32'(ov), 32'(m_ovr[m]));
        chk({p, " udr"},        32'(ud), 32'(m_udr[m]));
    endtask

    task automatic cycle(input bit r, input bit w, input bit rq, input bit c,
                         input logic [7:0] d);
        rst = r; wr = w; rd = rq; xrun_clr = c; din = d;
        @(posedge clk);
        model_step(r, w, rq, c, d);
        #1;
        cmp_inst(0, "keep", k_dcount, k_dout, k_valid, k_empty, k_full, k_aempty, k_afull,
                 k_ovr, k_udr);
        cmp_inst(1, "ovw", o_dcount, o_dout, o_valid, o_empty, o_full, o_aempty, o_afull,
                 o_ovr, o_udr);
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'(i + 1));
    endtask

    typedef struct {
        bit         r, w, rq, c;
        logic [7:0] d;
        int         dcount;
        logic [7:0] dout;
        bit         valid, ovr, udr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // reset, idle, empty read with write (no fall-through), clear, read back, hold
        tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 0, 8'h55, 1, 8'h00, 0, 0, 1};
        tbl[3] = '{0, 0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0};
        tbl[4] = '{0, 0, 1, 0, 8'h00, 0, 8'h55, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 8'h00, 0, 8'h55, 0, 0, 0};

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].r, tbl[i].w, tbl[i].rq, tbl[i].c, tbl[i].d);
            chk("tbl dcount", 32'(k_dcount), 32'(tbl[i].dcount));
            chk("tbl dout",   32'(k_dout),   32'(tbl[i].dout));
            chk("tbl valid",  32'(k_valid),  32'(tbl[i].valid));
            chk("tbl ovr",    32'(k_ovr),    32'(tbl[i].ovr));
            chk("tbl udr",    32'(k_udr),    32'(tbl[i].udr));
            $display("vector %0d: rst=%0d wr=%0d rd=%0d clr=%0d din=%02h -> dcount=%0d dout=%02h",
                     i, tbl[i].r, tbl[i].w, tbl[i].rq, tbl[i].c, tbl[i].d, k_dcount, k_dout);
        end

        // Reset with words stored returns to the idle state.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 8'(8'h30 + i));
        chk("pre-reset dcount", 32'(k_dcount), 32'd5);
        cycle(1, 1, 1, 0, 8'hEE);
        chk("reset dcount", 32'(k_dcount), 32'd0);
        chk("reset empty",  32'(k_empty),  32'd1);
        chk("reset aempty", 32'(k_aempty), 32'd1);
        chk("reset dout",   32'(k_dout),   32'd0);
        $display("sequence: reset with 5 words stored");

        // In-order fill and drain with flag thresholds.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 0, 8'(i + 1));
            chk("fill afull", 32'(k_afull), 32'(i + 1 >= 12));
            chk("fill full",  32'(k_full),  32'(i + 1 == 16));
        end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 0, 8'h00);
            chk("drain dout",  32'(k_dout),  32'(i + 1));
            chk("drain valid", 32'(k_valid), 32'd1);
        end
        cycle(0, 0, 0, 0, 8'h00);
        chk("drain empty", 32'(k_empty), 32'd1);
        $display("sequence: fill/drain 16 words");

        // Write into a full FIFO: KEEP drops it, OVERWRITE evicts the oldest.
        cycle(1, 0, 0, 0, 8'h00);
        fill16();
        cycle(0, 1, 0, 0, 8'hAA);
        chk("keep ovr",    32'(k_ovr),    32'd1);
        chk("ovw ovr",     32'(o_ovr),    32'd1);
        chk("keep dcount", 32'(k_dcount), 32'd16);
        chk("ovw dcount",  32'(o_dcount), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 0, 8'h00);
            chk("keep xrun dout", 32'(k_dout), 32'(i + 1));
            chk("ovw xrun dout",  32'(o_dout), (i < 15) ? 32'(i + 2) : 32'hAA);
        end
        $display("sequence: overrun KEEP vs OVERWRITE");

        // Simultaneous read and write at full: no overrun, new word last.
        cycle(1, 0, 0, 0, 8'h00);
        fill16();
        cycle(0, 1, 1, 0, 8'hBB);
        chk("rw full dcount", 32'(k_dcount), 32'd16);
        chk("rw full ovr",    32'(k_ovr),    32'd0);
        chk("rw full ovw ovr", 32'(o_ovr),   32'd0);
        chk("rw full dout",   32'(k_dout),   32'h01);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 0, 8'h00);
            chk("rw tail keep", 32'(k_dout), (i < 15) ? 32'(i + 2) : 32'hBB);
            chk("rw tail ovw",  32'(o_dout), (i < 15) ? 32'(i + 2) : 32'hBB);
        end
        $display("sequence: read+write at full");

        // Randomised traffic, phases biased toward full, empty and balanced.
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 250) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 25; pr = 75; end
                default: begin pw = 55; pr = 55; end
            endcase
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < pw),
                  ($urandom_range(0, 99) < pr),
                  ($urandom_range(0, 15) == 0),
                  8'($urandom));
        end
        $display("sequence: 3000 random cycles");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
